// File: rtl/uart_rx_pkg.sv
// Shared types, constants and the parity helper for the UART receive frame engine.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam int   MAX_WIDTH   = 9;

    // Zero-extended words keep the same XOR, so one fixed-width helper serves every WIDTH.
    function automatic logic exp_parity(input logic [MAX_WIDTH-1:0] data, input logic ptype);
        return (ptype == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_frame_check.sv
// UART receive frame engine: deserializes start/data/parity/stop bits, checks parity and stop bit.
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             parity_enable,
    input  logic             parity_type,
    input  logic             sampled_bit,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] P_DATA,
    output logic             data_valid,
    output logic             par_err,
    output logic             stp_err,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    rx_state_t r_state;
    rx_state_t w_state_next;

    logic [WIDTH-1:0]     r_shift;
    logic [CW-1:0]        r_cnt;
    logic                 r_par_en;
    logic                 r_par_type;
    logic                 r_par_fail;
    logic [WIDTH-1:0]     r_pdata;
    logic                 r_data_valid;
    logic                 r_par_err;
    logic                 r_stp_err;
    logic [MAX_WIDTH-1:0] w_shift_ext;
    logic                 w_exp_par;

    always_comb begin
        w_shift_ext              = '0;
        w_shift_ext[WIDTH-1:0]   = r_shift;
        w_exp_par                = exp_parity(w_shift_ext, r_par_type);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bit_valid) begin
            unique case (r_state)
                IDLE:    if (!sampled_bit) w_state_next = DATA;
                DATA:    if (r_cnt == LAST_BIT) w_state_next = r_par_en ? PARITY : STOP;
                PARITY:  w_state_next = STOP;
                STOP:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Error/valid strobes default low each cycle so they last exactly one clock.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_par_en     <= 1'b0;
            r_par_type   <= 1'b0;
            r_par_fail   <= 1'b0;
            r_pdata      <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            if (bit_valid) begin
                unique case (r_state)
                    IDLE: begin
                        if (!sampled_bit) begin
                            r_par_en   <= parity_enable;
                            r_par_type <= parity_type;
                            r_cnt      <= '0;
                            r_par_fail <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_shift <= {sampled_bit, r_shift[WIDTH-1:1]};
                        if (r_cnt != LAST_BIT) r_cnt <= r_cnt + 1'b1;
                    end
                    PARITY: begin
                        r_par_fail <= r_par_en && (sampled_bit != w_exp_par);
                    end
                    STOP: begin
                        r_data_valid <= !r_par_fail && sampled_bit;
                        r_par_err    <= r_par_fail;
                        r_stp_err    <= !sampled_bit;
                        if (!r_par_fail && sampled_bit) r_pdata <= r_shift;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign P_DATA     = r_pdata;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
- Receive-side frame engine for the UART RX path: deserializer, parity checker and stop-bit checker in one block.
- Consumes one already-sampled bit per bit period from the RX oversampler/edge counter (sampled_bit qualified by bit_valid).
- Tracks the frame start/data/parity/stop sequence, rebuilds the data word LSB-first and checks parity with the same convention the TX parity generator uses.
- Presents the word with a one-cycle data_valid strobe, or flags par_err/stp_err.

Parameters:
- WIDTH, 8, data bits per frame; legal range 5..9.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- parity_enable  input  1  1 = frame carries a parity bit after the data bits.
- parity_type  input  1  0 = even (expected parity = XOR of data); 1 = odd (expected parity = XNOR of data).
- sampled_bit  input  1  resolved line value for the current bit period.
- bit_valid  input  1  single-cycle strobe, at most one per bit period; sampled_bit is meaningful only while it is high.
- P_DATA  output  WIDTH  last correctly received word.
- data_valid  output  1  one-cycle pulse: P_DATA updated with a good frame.
- par_err  output  1  one-cycle pulse at frame end: parity mismatch.
- stp_err  output  1  one-cycle pulse at frame end: stop bit sampled as 0.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (RST=1 at a rising edge): state returns to IDLE from any state. P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, busy = 0. Shift register, bit counter and latched config are cleared. Any frame in progress is discarded with no error pulse.
- Only bit_valid cycles advance the FSM. Cycles without bit_valid hold all state.

FSM:
- IDLE:
  - bit_valid && sampled_bit==0: start bit. Latch parity_enable and parity_type. Clear bit counter. Go to DATA.
  - bit_valid && sampled_bit==1: stay in IDLE (idle line).
- DATA:
  - Each bit_valid shifts sampled_bit in at the MSB with a right shift, so the first data bit ends at P_DATA[0].
  - The counter increments from 0 to WIDTH-1.
  - On the WIDTH-th bit: go to PARITY if latched parity_enable=1, else go to STOP.
- PARITY:
  - On bit_valid: par_fail = (sampled_bit != expected). expected = ^shift when type=0, ~^shift when type=1.
  - Go to STOP.
- STOP:
  - On bit_valid: stp_fail = (sampled_bit == 0).
  - On that same clock edge, drive the registered outputs (visible for exactly the next cycle):
    - data_valid = !par_fail && !stp_fail.
    - par_err = par_fail.
    - stp_err = stp_fail.
    - If data_valid: P_DATA <= shift.
  - Go to IDLE.
- par_fail is always 0 when the latched parity_enable is 0.
- Both errors may pulse together. data_valid never pulses together with either error. P_DATA is unchanged on a bad frame.

Configuration and timing:
- parity_enable and parity_type changes mid-frame have no effect until the next start bit.
- busy is combinational from state: high from the cycle after the start-bit strobe through the cycle of the stop-bit strobe.
- Back-to-back frames: the FSM is in IDLE one cycle after the stop strobe, so the next bit_valid can be a start bit. No gap cycles are required.
- Latency: outputs are visible 1 cycle after the stop-bit bit_valid cycle.

Decomposition:
- Package uart_rx_pkg:
  - typedef enum logic [1:0] rx_state_t {IDLE, DATA, PARITY, STOP}.
  - Constants PARITY_EVEN=1'b0, PARITY_ODD=1'b1.
  - Function exp_parity(data, type).
- Single module; no sub-module warranted. The shift register, counter and FSM are tightly coupled.

Test Plan:
- Reset, then idle line (bit_valid with sampled_bit=1) ×5 -> busy stays 0, no output pulses, P_DATA=0x00.
- parity_enable=1, parity_type=0: start 0, data 0xA5 LSB-first, parity 0, stop 1 -> data_valid pulse 1 cycle, P_DATA=0xA5, par_err=0, stp_err=0.
- parity_type=1: frame with data 0xA5, parity bit 0 (expected 1) -> par_err pulse, data_valid=0, P_DATA stays 0xA5 from the previous frame.
- parity_enable=0: data 0x3C, stop bit 0 -> stp_err pulse, par_err=0, data_valid=0. Then data 0x3C, stop 1 -> data_valid, P_DATA=0x3C.
- Back-to-back frames 0x01 then 0xFE, with the next start strobe 2 cycles after the stop strobe -> two data_valid pulses, P_DATA=0x01 then 0xFE.
- RST asserted after the 4th data bit of a frame -> state IDLE next cycle, no pulses. A following full frame 0x5A is received correctly.
